// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel strobe, x/y counters, decoded sync/active, line/frame pulses.
// Define VGA_FRAME_COUNT_EN to compile in the frame counter; otherwise frame_count is tied to 0.
`timescale 1ns/1ps
module vga_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int CLK_DIV   = 2,
   parameter int XW        = 10,
   parameter int YW        = 10,
   parameter int FRAME_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   output logic               pix_en,
   output logic [XW-1:0]      pixel_x,
   output logic [YW-1:0]      pixel_y,
   output logic               vga_active,
   output logic               hsync,
   output logic               vsync,
   output logic               h_begin,
   output logic               v_begin,
   output logic [FRAME_W-1:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             div_last;
   logic             x_last;
   logic             y_last;
   logic             h_sync_on;
   logic             v_sync_on;

   assign div_last = (div_cnt == DIV_LAST);
   assign x_last   = (int'(pixel_x) == H_TOTAL - 1);
   assign y_last   = (int'(pixel_y) == V_TOTAL - 1);

   // Gating with rst_n keeps the strobe low in reset even when CLK_DIV=1 makes it follow ena.
   assign pix_en = rst_n & ena & div_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         pixel_x <= '0;
         pixel_y <= '0;
         h_begin <= 1'b0;
         v_begin <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register here samples its pre-edge neighbours.
         h_begin <= 1'b0;
         v_begin <= 1'b0;
         if (ena) begin
            div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
            if (div_last) begin
               if (x_last) begin
                  pixel_x <= '0;
                  h_begin <= 1'b1;
                  if (y_last) begin
                     pixel_y <= '0;
                     v_begin <= 1'b1;
                  end else begin
                     pixel_y <= pixel_y + YW'(1);
                  end
               end else begin
                  pixel_x <= pixel_x + XW'(1);
               end
            end
         end
      end
   end

   // Decoded straight from the counter registers, so they describe the current pixel with no lag.
   assign h_sync_on  = (int'(pixel_x) >= H_ACTIVE + H_FP) && (int'(pixel_x) < H_ACTIVE + H_FP + H_SYNC);
   assign v_sync_on  = (int'(pixel_y) >= V_ACTIVE + V_FP) && (int'(pixel_y) < V_ACTIVE + V_FP + V_SYNC);
   assign hsync      = h_sync_on ? HSYNC_POL : ~HSYNC_POL;
   assign vsync      = v_sync_on ? VSYNC_POL : ~VSYNC_POL;
   assign vga_active = (int'(pixel_x) < H_ACTIVE) && (int'(pixel_y) < V_ACTIVE);

`ifdef VGA_FRAME_COUNT_EN
   logic [FRAME_W-1:0] frame_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q <= '0;
      end else if (ena && div_last && x_last && y_last) begin
         frame_q <= frame_q + FRAME_W'(1);
      end
   end

   assign frame_count = frame_q;
`else
   assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, mid-size and tiny instances checked every clk against an elapsed-clock model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   typedef struct packed { int ha, hfp, hs, hbp, va, vfp, vs, vbp, hpol, vpol, d, fw; } cfg_t;
   typedef struct packed { int pe, x, y, act, hs, vs, hb, vb, fc; } obs_t;
   typedef struct packed { longint n; bit adv; } mst_t;

`ifdef VGA_FRAME_COUNT_EN
   localparam bit FC_ON = 1'b1;
`else
   localparam bit FC_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       d_rst_n, d_ena, d_pix_en, d_act, d_hs, d_vs, d_hb, d_vb;
   logic [9:0] d_x, d_y;
   logic [7:0] d_fc;
   logic       m_rst_n, m_ena, m_pix_en, m_act, m_hs, m_vs, m_hb, m_vb;
   logic [4:0] m_x, m_y;
   logic [1:0] m_fc;
   logic       s_rst_n, s_ena, s_pix_en, s_act, s_hs, s_vs, s_hb, s_vb;
   logic [2:0] s_x, s_y;
   logic [3:0] s_fc;

   vga_timing_gen u_def (
      .clk(clk), .rst_n(d_rst_n), .ena(d_ena), .pix_en(d_pix_en), .pixel_x(d_x), .pixel_y(d_y),
      .vga_active(d_act), .hsync(d_hs), .vsync(d_vs), .h_begin(d_hb), .v_begin(d_vb), .frame_count(d_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CLK_DIV(3), .XW(5), .YW(5), .FRAME_W(2)
   ) u_mid (
      .clk(clk), .rst_n(m_rst_n), .ena(m_ena), .pix_en(m_pix_en), .pixel_x(m_x), .pixel_y(m_y),
      .vga_active(m_act), .hsync(m_hs), .vsync(m_vs), .h_begin(m_hb), .v_begin(m_vb), .frame_count(m_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1), .XW(3), .YW(3), .FRAME_W(4)
   ) u_small (
      .clk(clk), .rst_n(s_rst_n), .ena(s_ena), .pix_en(s_pix_en), .pixel_x(s_x), .pixel_y(s_y),
      .vga_active(s_act), .hsync(s_hs), .vsync(s_vs), .h_begin(s_hb), .v_begin(s_vb), .frame_count(s_fc)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_obs(input string nm, input obs_t a, input obs_t e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s @%0t: got pe=%0d x=%0d y=%0d act=%0d hs=%0d vs=%0d hb=%0d vb=%0d fc=%0d, expected pe=%0d x=%0d y=%0d act=%0d hs=%0d vs=%0d hb=%0d vb=%0d fc=%0d",
                  nm, $time, a.pe, a.x, a.y, a.act, a.hs, a.vs, a.hb, a.vb, a.fc,
                  e.pe, e.x, e.y, e.act, e.hs, e.vs, e.hb, e.vb, e.fc);
      end
   endtask

   // Model state is just the number of enabled clocks since reset; everything else is derived from it.
   function automatic mst_t step(input cfg_t c, input mst_t m, input bit rst, input bit en);
      mst_t r = m;
      if (!rst) begin
         r.n   = 0;
         r.adv = 1'b0;
      end else if (en) begin
         r.adv = ((m.n % c.d) == c.d - 1);
         r.n   = m.n + 1;
      end else begin
         r.adv = 1'b0;
      end
      return r;
   endfunction

   function automatic obs_t model(input cfg_t c, input mst_t m, input bit rst, input bit en);
      obs_t   e;
      longint ht, vt, p;
      ht    = c.ha + c.hfp + c.hs + c.hbp;
      vt    = c.va + c.vfp + c.vs + c.vbp;
      p     = m.n / c.d;
      e.x   = int'(p % ht);
      e.y   = int'((p / ht) % vt);
      e.pe  = (rst && en && ((m.n % c.d) == c.d - 1)) ? 1 : 0;
      e.act = (e.x < c.ha && e.y < c.va) ? 1 : 0;
      e.hs  = (e.x >= c.ha + c.hfp && e.x < c.ha + c.hfp + c.hs) ? c.hpol : 1 - c.hpol;
      e.vs  = (e.y >= c.va + c.vfp && e.y < c.va + c.vfp + c.vs) ? c.vpol : 1 - c.vpol;
      e.hb  = (rst && m.adv && e.x == 0) ? 1 : 0;
      e.vb  = (rst && m.adv && e.x == 0 && e.y == 0) ? 1 : 0;
      e.fc  = FC_ON ? int'((p / (ht * vt)) % (longint'(1) << c.fw)) : 0;
      return e;
   endfunction

   initial begin
      cfg_t cd, cm, cs;
      mst_t md, mm, ms;
      obs_t a;
      cd = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 8};
      cm = '{20, 2, 3, 4, 12, 2, 2, 3, 1, 0, 3, 2};
      cs = '{4, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 4};
      md = '{0, 1'b0};
      mm = '{0, 1'b0};
      ms = '{0, 1'b0};
      forever begin
         @(posedge clk);
         md = step(cd, md, d_rst_n, d_ena);
         mm = step(cm, mm, m_rst_n, m_ena);
         ms = step(cs, ms, s_rst_n, s_ena);
         #1;
         a = '{int'(d_pix_en), int'(d_x), int'(d_y), int'(d_act), int'(d_hs), int'(d_vs), int'(d_hb), int'(d_vb), int'(d_fc)};
         check_obs("def", a, model(cd, md, d_rst_n, d_ena));
         a = '{int'(m_pix_en), int'(m_x), int'(m_y), int'(m_act), int'(m_hs), int'(m_vs), int'(m_hb), int'(m_vb), int'(m_fc)};
         check_obs("mid", a, model(cm, mm, m_rst_n, m_ena));
         a = '{int'(s_pix_en), int'(s_x), int'(s_y), int'(s_act), int'(s_hs), int'(s_vs), int'(s_hb), int'(s_vb), int'(s_fc)};
         check_obs("small", a, model(cs, ms, s_rst_n, s_ena));
      end
   end

   task automatic run_def();
      int first_hb = 0, second_hb = 0, hs_low = 0, hs_bad = 0, act_pix = 0, hold_bad = 0;
      bit found = 1'b0;
      d_rst_n = 1'b1;
      for (int e = 1; e <= 3300; e++) begin
         @(posedge clk); #1;
         if (e == 1) begin
            check("def_first_pix_en", d_pix_en, 1);
            check("def_x_at_first_strobe", d_x, 0);
         end
         if (e == 2) check("def_x_after_first_strobe", d_x, 1);
         if (d_hb) begin
            if (first_hb == 0) first_hb = e;
            else if (second_hb == 0) second_hb = e;
         end
         if (e <= 1600) begin
            if (!d_hs) begin
               hs_low++;
               if (d_x < 656 || d_x > 751) hs_bad++;
            end
            if (d_act && d_pix_en) act_pix++;
         end
      end
      check("def_first_h_begin_clk", first_hb, 1600);
      check("def_second_h_begin_clk", second_hb, 3200);
      check("def_hsync_low_clks", hs_low, 192);
      check("def_hsync_low_outside_656_751", hs_bad, 0);
      check("def_active_pixels_line0", act_pix, 640);

      for (int e = 0; e < 2000 && !found; e++) begin
         @(posedge clk); #1;
         if (d_x == 100) found = 1'b1;
      end
      check("def_reached_x100", found, 1);
      @(negedge clk); d_ena = 1'b0;
      repeat (37) begin
         @(posedge clk); #1;
         if (d_x != 100 || d_pix_en) hold_bad++;
      end
      check("def_hold_frozen", hold_bad, 0);
      @(negedge clk); d_ena = 1'b1;
      @(posedge clk); #1;
      check("def_resume_strobe", d_pix_en, 1);
      check("def_resume_x_1clk", d_x, 100);
      @(posedge clk); #1;
      check("def_resume_x_2clk", d_x, 101);
   endtask

   task automatic run_mid();
      int e = 0, vb_cnt = 0, first_vb = 0, vs_low = 0, act_pix = 0, vb_after = 0;
      bit found = 1'b0;
      m_rst_n = 1'b1;
      while (vb_cnt < 5 && e < 6 * 1653) begin
         @(posedge clk); #1;
         e++;
         if (e <= 1653) begin
            if (!m_vs) vs_low++;
            if (m_act && m_pix_en) act_pix++;
         end
         if (m_vb) begin
            vb_cnt++;
            if (vb_cnt == 1) first_vb = e;
            check($sformatf("mid_frame_count_after_%0d", vb_cnt), m_fc, FC_ON ? vb_cnt % 4 : 0);
         end
      end
      check("mid_v_begin_count", vb_cnt, 5);
      check("mid_first_v_begin_clk", first_vb, 1653);
      check("mid_vsync_low_clks", vs_low, 174);
      check("mid_active_pixels_frame0", act_pix, 240);

      for (int i = 0; i < 2000 && !found; i++) begin
         @(posedge clk); #1;
         if (m_x == 15 && m_y == 7) found = 1'b1;
      end
      check("mid_reached_15_7", found, 1);
      #3 m_rst_n = 1'b0;
      #1;
      check("mid_async_rst_x", m_x, 0);
      check("mid_async_rst_y", m_y, 0);
      check("mid_async_rst_active", m_act, 1);
      check("mid_async_rst_hsync", m_hs, 0);
      check("mid_async_rst_vsync", m_vs, 1);
      check("mid_async_rst_pix_en", m_pix_en, 0);
      check("mid_async_rst_frame", m_fc, 0);
      repeat (2) @(negedge clk);
      m_rst_n = 1'b1;
      repeat (300) begin
         @(posedge clk); #1;
         if (m_vb || m_hb && m_y == 0) vb_after++;
      end
      check("mid_no_v_begin_after_release", vb_after, 0);
   endtask

   task automatic run_small();
      int both_first = 0, both_second = 0, lone_vb = 0, hs_hi = 0, hs_bad = 0, hb_cnt = 0;
      s_rst_n = 1'b1;
      for (int e = 1; e <= 70; e++) begin
         @(posedge clk); #1;
         if (s_hb && s_vb) begin
            if (both_first == 0) both_first = e;
            else if (both_second == 0) both_second = e;
         end
         if (s_vb && !s_hb) lone_vb++;
         if (e <= 35) begin
            if (s_hb) hb_cnt++;
            if (s_hs) begin
               hs_hi++;
               if (s_x != 5) hs_bad++;
            end
         end
      end
      check("small_first_frame_wrap_clk", both_first, 35);
      check("small_second_frame_wrap_clk", both_second, 70);
      check("small_v_begin_without_h_begin", lone_vb, 0);
      check("small_h_begin_per_frame", hb_cnt, 5);
      check("small_hsync_high_clks", hs_hi, 5);
      check("small_hsync_high_off_x5", hs_bad, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      d_rst_n = 1'b0; m_rst_n = 1'b0; s_rst_n = 1'b0;
      d_ena   = 1'b1; m_ena   = 1'b1; s_ena   = 1'b1;
      repeat (3) @(negedge clk);
      check("def_rst_x", d_x, 0);
      check("def_rst_y", d_y, 0);
      check("def_rst_active", d_act, 1);
      check("def_rst_hsync", d_hs, 1);
      check("def_rst_vsync", d_vs, 1);
      check("def_rst_pix_en", d_pix_en, 0);
      check("def_rst_pulses", {d_hb, d_vb}, 0);
      check("def_rst_frame", d_fc, 0);
      check("small_rst_pix_en", s_pix_en, 0);
      check("small_rst_syncs", {s_hs, s_vs}, 0);
      check("mid_rst_syncs", {m_hs, m_vs}, 1);
      fork
         run_def();
         run_mid();
         run_small();
      join
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
